// File: rtl/rv32im_hazard_pkg.sv
// Shared types and constants for the RV32IM pipeline hazard unit.
package rv32im_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_e;

    localparam int DEFAULT_MUL_LATENCY = 1;
    localparam int DEFAULT_DIV_LATENCY = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rv32im_hazard_if.sv
// Pipeline-side bus of the hazard unit: stage register addresses/enables in, stage controls out.
interface rv32im_hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] i_id_rs1_addr;
    logic [REG_ADDR_W-1:0] i_id_rs2_addr;
    logic                  i_id_uses_rs1;
    logic                  i_id_uses_rs2;
    logic [REG_ADDR_W-1:0] i_ex_rs1_addr;
    logic [REG_ADDR_W-1:0] i_ex_rs2_addr;
    logic [REG_ADDR_W-1:0] i_ex_rd_addr;
    logic                  i_ex_reg_write_en;
    logic                  i_ex_mem_read_en;
    logic                  i_ex_is_muldiv;
    logic                  i_ex_is_div;
    logic [REG_ADDR_W-1:0] i_mem_rd_addr;
    logic                  i_mem_reg_write_en;
    logic [REG_ADDR_W-1:0] i_wb_rd_addr;
    logic                  i_wb_reg_write_en;
    logic                  i_redirect;
    logic                  i_cnt_clear;

    logic                  o_if_id_en;
    logic                  o_id_ex_en;
    logic                  o_ex_mem_en;
    logic                  o_mem_wb_en;
    logic                  o_if_id_flush;
    logic                  o_id_ex_flush;
    logic                  o_ex_mem_bubble;
    logic [1:0]            o_fwd_a_sel;
    logic [1:0]            o_fwd_b_sel;
    logic                  o_muldiv_start;
    logic                  o_muldiv_busy;
    logic [CNT_W-1:0]      o_stall_cycles;
    logic [CNT_W-1:0]      o_flush_count;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_reg_write_en,
               i_ex_mem_read_en, i_ex_is_muldiv, i_ex_is_div,
               i_mem_rd_addr, i_mem_reg_write_en, i_wb_rd_addr, i_wb_reg_write_en,
               i_redirect, i_cnt_clear,
        input  o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_bubble,
               o_fwd_a_sel, o_fwd_b_sel, o_muldiv_start, o_muldiv_busy,
               o_stall_cycles, o_flush_count
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_reg_write_en,
               i_ex_mem_read_en, i_ex_is_muldiv, i_ex_is_div,
               i_mem_rd_addr, i_mem_reg_write_en, i_wb_rd_addr, i_wb_reg_write_en,
               i_redirect, i_cnt_clear,
        output o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_bubble,
               o_fwd_a_sel, o_fwd_b_sel, o_muldiv_start, o_muldiv_busy,
               o_stall_cycles, o_flush_count
    );

endinterface

// File: rtl/rv32im_muldiv_seq.sv
// MUL/DIV occupancy sequencer: holds the M-extension op in EX for its full latency.
module rv32im_muldiv_seq
    import rv32im_hazard_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic is_muldiv,
    input  logic is_div,
    output logic start,
    output logic busy,
    output logic stall
);

    localparam int MAX_L = max_int(MUL_LATENCY, DIV_LATENCY);
    localparam int CW    = max_int($clog2(MAX_L), 1);

    // The IDLE cycle is the first stall, so BUSY only needs L-2 more before release
    localparam logic [CW-1:0] MUL_LOAD = CW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
    localparam logic [CW-1:0] DIV_LOAD = CW'((DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0);

    muldiv_state_e state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          multi_cycle;

    assign multi_cycle = is_div ? (DIV_LATENCY > 1) : (MUL_LATENCY > 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        busy       = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (is_muldiv) begin
                    start = 1'b1;
                    if (multi_cycle) begin
                        stall      = 1'b1;
                        cnt_next   = is_div ? DIV_LOAD : MUL_LOAD;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt != '0) begin
                    stall    = 1'b1;
                    cnt_next = cnt - CW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/rv32im_hazard_unit.sv
// Five-stage RV32IM pipeline control: forwarding, load-use/data stalls, M-op stalls,
// redirect flushes and saturating performance counters.
module rv32im_hazard_unit
    import rv32im_hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int FWD_EN      = 1,
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY,
    parameter int CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    rv32im_hazard_if.slave hz
);

    function automatic logic hit(input logic [REG_ADDR_W-1:0] src,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic                  we);
        return we && (rd != '0) && (src == rd);
    endfunction

    logic     mem_a, mem_b, wb_a, wb_b;
    logic     id_hit_ex, id_hit_mem, hazard_stall;
    logic     md_start, md_busy, md_stall;
    logic     if_id_en, id_ex_en, if_id_flush, id_ex_flush, bubble;
    fwd_sel_e fwd_a, fwd_b;

    assign mem_a = hit(hz.i_ex_rs1_addr, hz.i_mem_rd_addr, hz.i_mem_reg_write_en);
    assign mem_b = hit(hz.i_ex_rs2_addr, hz.i_mem_rd_addr, hz.i_mem_reg_write_en);
    assign wb_a  = hit(hz.i_ex_rs1_addr, hz.i_wb_rd_addr, hz.i_wb_reg_write_en);
    assign wb_b  = hit(hz.i_ex_rs2_addr, hz.i_wb_rd_addr, hz.i_wb_reg_write_en);

    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (FWD_EN != 0) begin
            if (mem_a)     fwd_a = FWD_MEM;
            else if (wb_a) fwd_a = FWD_WB;
            if (mem_b)     fwd_b = FWD_MEM;
            else if (wb_b) fwd_b = FWD_WB;
        end
    end

    assign id_hit_ex  = (hz.i_id_uses_rs1 && hit(hz.i_id_rs1_addr, hz.i_ex_rd_addr, hz.i_ex_reg_write_en))
                     || (hz.i_id_uses_rs2 && hit(hz.i_id_rs2_addr, hz.i_ex_rd_addr, hz.i_ex_reg_write_en));
    assign id_hit_mem = (hz.i_id_uses_rs1 && hit(hz.i_id_rs1_addr, hz.i_mem_rd_addr, hz.i_mem_reg_write_en))
                     || (hz.i_id_uses_rs2 && hit(hz.i_id_rs2_addr, hz.i_mem_rd_addr, hz.i_mem_reg_write_en));

    // With forwarding only a load in EX is too late; without it any EX/MEM producer is
    assign hazard_stall = (FWD_EN != 0) ? (id_hit_ex && hz.i_ex_mem_read_en)
                                        : (id_hit_ex || id_hit_mem);

    rv32im_muldiv_seq #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_LATENCY (DIV_LATENCY)
    ) u_muldiv_seq (
        .clk       (clk),
        .rst       (rst),
        .is_muldiv (hz.i_ex_is_muldiv),
        .is_div    (hz.i_ex_is_div),
        .start     (md_start),
        .busy      (md_busy),
        .stall     (md_stall)
    );

    always_comb begin
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        bubble      = 1'b0;
        if (md_stall) begin
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            bubble   = 1'b1;
        end else if (hz.i_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hazard_stall) begin
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign hz.o_if_id_en      = if_id_en;
    assign hz.o_id_ex_en      = id_ex_en;
    assign hz.o_ex_mem_en     = 1'b1;
    assign hz.o_mem_wb_en     = 1'b1;
    assign hz.o_if_id_flush   = if_id_flush;
    assign hz.o_id_ex_flush   = id_ex_flush;
    assign hz.o_ex_mem_bubble = bubble;
    assign hz.o_fwd_a_sel     = fwd_a;
    assign hz.o_fwd_b_sel     = fwd_b;
    assign hz.o_muldiv_start  = md_start;
    assign hz.o_muldiv_busy   = md_busy;

    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             stall_inc;

    assign stall_inc = !if_id_en && !hz.i_redirect;

    always_ff @(posedge clk) begin
        if (rst || hz.i_cnt_clear) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.i_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.o_stall_cycles = stall_cnt;
    assign hz.o_flush_count  = flush_cnt;

    // The core must never resolve a branch while an M op still occupies EX
    assert property (@(posedge clk) disable iff (rst) !(md_busy && hz.i_redirect));

endmodule

// File: tb/tb_rv32im_hazard_unit.sv
// Directed bench: dut_a forwards (MUL=1, DIV=4, 4-bit counters), dut_b is stall-only (MUL=2, DIV=3).
module tb_rv32im_hazard_unit;

    localparam logic [6:0] NORM = 7'b1111000;
    localparam logic [6:0] LU   = 7'b0111010;
    localparam logic [6:0] RD   = 7'b1111110;
    localparam logic [6:0] MD   = 7'b0011001;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       use1;
        logic       use2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic       ex_mr;
        logic       is_md;
        logic       is_div;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       redirect;
        logic       clr;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] a_ctl;
        logic [1:0] a_fa;
        logic [1:0] a_fb;
        logic [6:0] b_ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rv32im_hazard_if #(.REG_ADDR_W(5), .CNT_W(4))  ifa ();
    rv32im_hazard_if #(.REG_ADDR_W(5), .CNT_W(32)) ifb ();

    assign ifa.i_id_rs1_addr      = cur.id_rs1;   assign ifb.i_id_rs1_addr      = cur.id_rs1;
    assign ifa.i_id_rs2_addr      = cur.id_rs2;   assign ifb.i_id_rs2_addr      = cur.id_rs2;
    assign ifa.i_id_uses_rs1      = cur.use1;     assign ifb.i_id_uses_rs1      = cur.use1;
    assign ifa.i_id_uses_rs2      = cur.use2;     assign ifb.i_id_uses_rs2      = cur.use2;
    assign ifa.i_ex_rs1_addr      = cur.ex_rs1;   assign ifb.i_ex_rs1_addr      = cur.ex_rs1;
    assign ifa.i_ex_rs2_addr      = cur.ex_rs2;   assign ifb.i_ex_rs2_addr      = cur.ex_rs2;
    assign ifa.i_ex_rd_addr       = cur.ex_rd;    assign ifb.i_ex_rd_addr       = cur.ex_rd;
    assign ifa.i_ex_reg_write_en  = cur.ex_we;    assign ifb.i_ex_reg_write_en  = cur.ex_we;
    assign ifa.i_ex_mem_read_en   = cur.ex_mr;    assign ifb.i_ex_mem_read_en   = cur.ex_mr;
    assign ifa.i_ex_is_muldiv     = cur.is_md;    assign ifb.i_ex_is_muldiv     = cur.is_md;
    assign ifa.i_ex_is_div        = cur.is_div;   assign ifb.i_ex_is_div        = cur.is_div;
    assign ifa.i_mem_rd_addr      = cur.mem_rd;   assign ifb.i_mem_rd_addr      = cur.mem_rd;
    assign ifa.i_mem_reg_write_en = cur.mem_we;   assign ifb.i_mem_reg_write_en = cur.mem_we;
    assign ifa.i_wb_rd_addr       = cur.wb_rd;    assign ifb.i_wb_rd_addr       = cur.wb_rd;
    assign ifa.i_wb_reg_write_en  = cur.wb_we;    assign ifb.i_wb_reg_write_en  = cur.wb_we;
    assign ifa.i_redirect         = cur.redirect; assign ifb.i_redirect         = cur.redirect;
    assign ifa.i_cnt_clear        = cur.clr;      assign ifb.i_cnt_clear        = cur.clr;

    rv32im_hazard_unit #(
        .REG_ADDR_W (5), .FWD_EN (1), .MUL_LATENCY (1), .DIV_LATENCY (4), .CNT_W (4)
    ) dut_a (
        .clk (clk), .rst (rst), .hz (ifa)
    );

    rv32im_hazard_unit #(
        .REG_ADDR_W (5), .FWD_EN (0), .MUL_LATENCY (2), .DIV_LATENCY (3), .CNT_W (32)
    ) dut_b (
        .clk (clk), .rst (rst), .hz (ifb)
    );

    logic [6:0] ctl_a, ctl_b;
    assign ctl_a = {ifa.o_if_id_en, ifa.o_id_ex_en, ifa.o_ex_mem_en, ifa.o_mem_wb_en,
                    ifa.o_if_id_flush, ifa.o_id_ex_flush, ifa.o_ex_mem_bubble};
    assign ctl_b = {ifb.o_if_id_en, ifb.o_id_ex_en, ifb.o_ex_mem_en, ifb.o_mem_wb_en,
                    ifb.o_if_id_flush, ifb.o_id_ex_flush, ifb.o_ex_mem_bubble};

    task automatic applyStimulus(input in_t v);
        @(posedge clk);
        #1;
        cur = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic resetDuts();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t       tv[$];
        in_t        v_idle, v_clr, v_lu, v_lr, v_div, v_mul;
        logic [5:0] bb_start, bb_busy, bb_stall;

        // Field order: id_rs1,id_rs2,use1,use2, ex_rs1,ex_rs2,ex_rd,ex_we,ex_mr, is_md,is_div,
        //              mem_rd,mem_we, wb_rd,wb_we, redirect,clr
        tv.push_back('{'{0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0, 0,0}, NORM, 2'd0, 2'd0, NORM});
        tv.push_back('{'{0,0,0,0, 5,0,0,0,0, 0,0, 5,1, 5,1, 0,0}, NORM, 2'd1, 2'd0, NORM});
        tv.push_back('{'{0,0,0,0, 5,0,0,0,0, 0,0, 0,1, 5,1, 0,0}, NORM, 2'd2, 2'd0, NORM});
        tv.push_back('{'{0,0,0,0, 5,0,0,0,0, 0,0, 0,1, 5,0, 0,0}, NORM, 2'd0, 2'd0, NORM});
        tv.push_back('{'{0,0,0,0, 9,7,0,0,0, 0,0, 7,1, 9,1, 0,0}, NORM, 2'd2, 2'd1, NORM});
        tv.push_back('{'{0,0,0,0, 7,7,0,0,0, 0,0, 7,0, 7,1, 0,0}, NORM, 2'd2, 2'd2, NORM});
        tv.push_back('{'{3,1,1,1, 0,0,3,1,1, 0,0, 0,0, 0,0, 0,0}, LU,   2'd0, 2'd0, LU});
        tv.push_back('{'{3,1,0,1, 0,0,3,1,1, 0,0, 0,0, 0,0, 0,0}, NORM, 2'd0, 2'd0, NORM});
        tv.push_back('{'{3,1,1,1, 0,0,3,1,0, 0,0, 0,0, 0,0, 0,0}, NORM, 2'd0, 2'd0, LU});
        tv.push_back('{'{0,4,0,1, 0,0,0,0,0, 0,0, 4,1, 0,0, 0,0}, NORM, 2'd0, 2'd0, LU});
        tv.push_back('{'{0,0,1,0, 0,0,0,1,1, 0,0, 0,0, 0,0, 0,0}, NORM, 2'd0, 2'd0, NORM});
        tv.push_back('{'{3,1,1,1, 0,0,3,1,1, 0,0, 0,0, 0,0, 1,0}, RD,   2'd0, 2'd0, RD});
        tv.push_back('{'{0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0, 1,0}, RD,   2'd0, 2'd0, RD});
        tv.push_back('{'{3,1,1,1, 0,0,3,0,1, 0,0, 0,0, 0,0, 0,0}, NORM, 2'd0, 2'd0, NORM});
        tv.push_back('{'{6,0,1,0, 0,0,0,0,0, 0,0, 0,0, 6,1, 0,0}, NORM, 2'd0, 2'd0, NORM});

        v_idle = '0;
        v_clr = '0;       v_clr.clr = 1'b1;
        v_lu = tv[6].in;
        v_lr = tv[11].in;
        v_div = '0;       v_div.is_md = 1'b1; v_div.is_div = 1'b1;
        v_mul = '0;       v_mul.is_md = 1'b1;

        // Reset state with idle inputs
        resetDuts();
        @(negedge clk);
        checkOutput("reset a_ctl", ctl_a, NORM);
        checkOutput("reset b_ctl", ctl_b, NORM);
        checkOutput("reset a_fwd", {ifa.o_fwd_a_sel, ifa.o_fwd_b_sel}, 4'h0);
        checkOutput("reset a_start_busy", {ifa.o_muldiv_start, ifa.o_muldiv_busy}, 2'b00);
        checkOutput("reset a_stall_cnt", ifa.o_stall_cycles, 4'd0);
        checkOutput("reset a_flush_cnt", ifa.o_flush_count, 4'd0);

        foreach (tv[i]) begin
            applyStimulus(tv[i].in);
            @(negedge clk);
            checkOutput($sformatf("v%0d a_ctl", i), ctl_a, tv[i].a_ctl);
            checkOutput($sformatf("v%0d a_fwd_a", i), ifa.o_fwd_a_sel, tv[i].a_fa);
            checkOutput($sformatf("v%0d a_fwd_b", i), ifa.o_fwd_b_sel, tv[i].a_fb);
            checkOutput($sformatf("v%0d b_ctl", i), ctl_b, tv[i].b_ctl);
            checkOutput($sformatf("v%0d b_fwd", i), {ifb.o_fwd_a_sel, ifb.o_fwd_b_sel}, 4'h0);
        end

        // Load-use counts one stall cycle; redirect on top of it counts only a flush
        applyStimulus(v_clr);
        applyStimulus(v_lu);
        applyStimulus(v_idle);
        @(negedge clk);
        checkOutput("lu a_stall_cnt", ifa.o_stall_cycles, 4'd1);
        checkOutput("lu b_stall_cnt", ifb.o_stall_cycles, 32'd1);
        checkOutput("lu a_flush_cnt", ifa.o_flush_count, 4'd0);
        applyStimulus(v_lr);
        @(negedge clk);
        checkOutput("redir a_ctl", ctl_a, RD);
        applyStimulus(v_idle);
        @(negedge clk);
        checkOutput("redir a_flush_cnt", ifa.o_flush_count, 4'd1);
        checkOutput("redir a_stall_cnt", ifa.o_stall_cycles, 4'd1);

        // DIV latency 4 on dut_a: start pulse, 3 stall/bubble cycles, EX occupied 4 cycles
        resetDuts();
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c < 4) ? v_div : v_idle);
            @(negedge clk);
            checkOutput($sformatf("div4 c%0d ctl", c), ctl_a, (c < 3) ? MD : NORM);
            checkOutput($sformatf("div4 c%0d start", c), ifa.o_muldiv_start, (c == 0));
            checkOutput($sformatf("div4 c%0d busy", c), ifa.o_muldiv_busy, (c >= 1 && c <= 3));
        end
        checkOutput("div4 a_stall_cnt", ifa.o_stall_cycles, 4'd3);

        // MUL latency 1 on dut_a: start pulse only, never BUSY
        resetDuts();
        applyStimulus(v_mul);
        @(negedge clk);
        checkOutput("mul1 c0 ctl", ctl_a, NORM);
        checkOutput("mul1 c0 start_busy", {ifa.o_muldiv_start, ifa.o_muldiv_busy}, 2'b10);
        applyStimulus(v_idle);
        @(negedge clk);
        checkOutput("mul1 c1 start_busy", {ifa.o_muldiv_start, ifa.o_muldiv_busy}, 2'b00);
        checkOutput("mul1 a_stall_cnt", ifa.o_stall_cycles, 4'd0);

        // Back-to-back mul (L=2) then div (L=3) on dut_b
        bb_start = 6'b000101;
        bb_busy  = 6'b011010;
        bb_stall = 6'b001101;
        resetDuts();
        for (int c = 0; c < 6; c++) begin
            applyStimulus((c < 2) ? v_mul : ((c < 5) ? v_div : v_idle));
            @(negedge clk);
            checkOutput($sformatf("b2b c%0d start", c), ifb.o_muldiv_start, bb_start[c]);
            checkOutput($sformatf("b2b c%0d busy", c), ifb.o_muldiv_busy, bb_busy[c]);
            checkOutput($sformatf("b2b c%0d ctl", c), ctl_b, bb_stall[c] ? MD : NORM);
        end
        checkOutput("b2b b_stall_cnt", ifb.o_stall_cycles, 32'd3);

        // Reset on the second BUSY cycle of a div on dut_a
        resetDuts();
        applyStimulus(v_div);
        applyStimulus(v_div);
        applyStimulus(v_div);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstbusy c2 busy", ifa.o_muldiv_busy, 1'b1);
        applyStimulus(v_idle);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstbusy c3 busy", ifa.o_muldiv_busy, 1'b0);
        checkOutput("rstbusy c3 ctl", ctl_a, NORM);
        checkOutput("rstbusy a_stall_cnt", ifa.o_stall_cycles, 4'd0);

        // 20 stall cycles saturate the 4-bit counter but not the 32-bit one
        resetDuts();
        repeat (20) applyStimulus(v_lu);
        applyStimulus(v_idle);
        @(negedge clk);
        checkOutput("sat a_stall_cnt", ifa.o_stall_cycles, 4'hF);
        checkOutput("sat b_stall_cnt", ifb.o_stall_cycles, 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
